// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential unsigned divider
package div_pkg;

   localparam int DIV_WIDTH = 64;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one combinational radix-2 restoring divide iteration
module div_restoring_step #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   // The shifted partial remainder needs one extra bit; once restored it is
   // always below the divisor, so the result fits back into WIDTH bits.
   logic [WIDTH:0] shifted;

   assign shifted = {rem_in, q_msb};
   assign q_bit   = (shifted >= {1'b0, divisor});
   assign rem_out = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];

endmodule

// File: rtl/unsigned_divider_seq_64.sv
// rtl/unsigned_divider_seq_64.sv - sequential restoring divider, one quotient bit per clock; optional DIV_ZERO_EARLY_EN
module unsigned_divider_seq_64
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] d_reg;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic             accept;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign quotient  = q_reg;
   assign remainder = r_reg;

   div_restoring_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (r_reg),
      .q_msb   (q_reg[WIDTH-1]),
      .divisor (d_reg),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state: RUN spends one extra cycle at cnt==0 before DONE, giving WIDTH+1 latency
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef DIV_ZERO_EARLY_EN
               if (divisor == '0)
                  state_nxt = DONE;
               else
                  state_nxt = RUN;
`else
               state_nxt = RUN;
`endif
            end
         end
         RUN: begin
            if (cnt == '0)
               state_nxt = DONE;
         end
         DONE: begin
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: load operands on accept, then one restoring iteration per RUN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg <= '0;
         r_reg <= '0;
         d_reg <= '0;
         cnt   <= '0;
      end else if (accept) begin
         d_reg <= divisor;
         q_reg <= dividend;
         r_reg <= '0;
         cnt   <= CW'(WIDTH);
`ifdef DIV_ZERO_EARLY_EN
         if (divisor == '0) begin
            q_reg <= '1;
            r_reg <= dividend;
            cnt   <= '0;
         end
`endif
      end else if (state == RUN && cnt != '0) begin
         r_reg <= step_rem;
         q_reg <= {q_reg[WIDTH-2:0], step_q};
         cnt   <= cnt - CW'(1);
      end
   end

`ifdef DIV_ZERO_EARLY_EN
   logic dz_reg;

   // Division-by-zero flag captured at acceptance, held through DONE
   always_ff @(posedge clk) begin
      if (rst)
         dz_reg <= 1'b0;
      else if (accept)
         dz_reg <= (divisor == '0);
   end

   assign div_zero = dz_reg;
`else
   assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_unsigned_divider_seq_64.sv
// tb/tb_unsigned_divider_seq_64.sv - directed self-checking bench for unsigned_divider_seq_64
module tb_unsigned_divider_seq_64;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] dividend;
   logic [63:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] quotient;
   logic [63:0] remainder;
   logic        div_zero;

   int tests;
   int fails;

   unsigned_divider_seq_64 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] qo, output logic [63:0] ro,
                         output logic dzo, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 300) begin
         step();
         n++;
      end
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      end
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 300) begin
         step();
         lat++;
      end
      qo  = quotient;
      ro  = remainder;
      dzo = div_zero;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 64'd0 ||
          remainder !== 64'd0 || div_zero !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b q=%h r=%h dz=%b required 1 0 0 0 0",
                  in_ready, out_valid, quotient, remainder, div_zero);
      end
   endtask

   task automatic test_basic();
      logic [63:0] q, r;
      logic dz;
      int lat;
      run_op(64'd100, 64'd7, q, r, dz, lat);
      tests++;
      if (q !== 64'd14 || r !== 64'd2 || dz !== 1'b0) begin
         fails++;
         $display("FAIL basic_100_7: q=%0d r=%0d dz=%b required 14 2 0", q, r, dz);
      end
      tests++;
      if (lat !== 65) begin
         fails++;
         $display("FAIL basic_latency: %0d cycles required 65", lat);
      end
      release_result();
   endtask

   task automatic test_patterns();
      logic [63:0] q, r;
      logic dz;
      int lat;
      run_op(64'h3489BE8F00000000, 64'h00000000FFFFFFFF, q, r, dz, lat);
      tests++;
      if (q !== 64'h3489BE8F || r !== 64'h3489BE8F) begin
         fails++;
         $display("FAIL pattern_hi32: q=%h r=%h required 3489be8f 3489be8f", q, r);
      end
      release_result();

      run_op(64'hFFFFFFFFFFFFFFFF, 64'd1, q, r, dz, lat);
      tests++;
      if (q !== 64'hFFFFFFFFFFFFFFFF || r !== 64'd0) begin
         fails++;
         $display("FAIL max_div_1: q=%h r=%h required ffffffffffffffff 0", q, r);
      end
      release_result();

      run_op(64'd3, 64'hFFFFFFFFFFFFFFFF, q, r, dz, lat);
      tests++;
      if (q !== 64'd0 || r !== 64'd3) begin
         fails++;
         $display("FAIL small_div_max: q=%h r=%h required 0 3", q, r);
      end
      release_result();
   endtask

   task automatic test_div_zero();
      logic [63:0] q, r;
      logic dz;
      int lat;
      run_op(64'd5, 64'd0, q, r, dz, lat);
      tests++;
      if (q !== 64'hFFFFFFFFFFFFFFFF || r !== 64'd5) begin
         fails++;
         $display("FAIL div_zero_values: q=%h r=%h required ffffffffffffffff 5", q, r);
      end
`ifdef DIV_ZERO_EARLY_EN
      tests++;
      if (dz !== 1'b1 || lat > 1) begin
         fails++;
         $display("FAIL div_zero_early: dz=%b lat=%0d required 1 and <=1", dz, lat);
      end
`else
      tests++;
      if (dz !== 1'b0 || lat !== 65) begin
         fails++;
         $display("FAIL div_zero_full: dz=%b lat=%0d required 0 65", dz, lat);
      end
`endif
      release_result();
   endtask

   task automatic test_backpressure();
      int n;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_start_idle: in_ready=%b required 1", in_ready);
      end
      dividend = 64'd100;
      divisor  = 64'd7;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) step();
      // offer a different operand pair while busy; it must be ignored
      dividend = 64'd50;
      divisor  = 64'd5;
      in_valid = 1'b1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL busy_in_ready: in_ready=%b required 0", in_ready);
      end
      n = 0;
      while (!out_valid && n < 300) begin
         step();
         n++;
      end
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || quotient !== 64'd14 || remainder !== 64'd2) begin
         fails++;
         $display("FAIL busy_ignored: out_valid=%b q=%0d r=%0d required 1 14 2",
                  out_valid, quotient, remainder);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             quotient !== 64'd14 || remainder !== 64'd2) begin
            fails++;
            $display("FAIL hold_cycle_%0d: out_valid=%b in_ready=%b q=%0d r=%0d required 1 0 14 2",
                     i, out_valid, in_ready, quotient, remainder);
         end
      end
      release_result();
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL handshake_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL idle_out_ready: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [63:0] q, r;
      logic dz;
      int lat;
      dividend = 64'hDEADBEEF12345678;
      divisor  = 64'd3;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 64'd0 ||
          remainder !== 64'd0 || div_zero !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_run: in_ready=%b out_valid=%b q=%h r=%h dz=%b required 1 0 0 0 0",
                  in_ready, out_valid, quotient, remainder, div_zero);
      end
      run_op(64'd100, 64'd7, q, r, dz, lat);
      tests++;
      if (q !== 64'd14 || r !== 64'd2 || lat !== 65) begin
         fails++;
         $display("FAIL after_reset_op: q=%0d r=%0d lat=%0d required 14 2 65", q, r, lat);
      end
      release_result();
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = 64'd0;
      divisor   = 64'd0;
      test_reset();
      test_basic();
      test_patterns();
      test_div_zero();
      test_backpressure();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
